// File: rtl/iob_word_serializer_pkg.sv
// Shared constants for the word serializer: FSM encodings and default width.
package iob_word_serializer_pkg;

    localparam int unsigned DATA_W_DEFAULT = 21;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/iob_word_serializer_if.sv
// Word-side handshake and bit-side serial bus of the word serializer.
interface iob_word_serializer_if
    import iob_word_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              tick_i;
    logic              s_o;
    logic              s_valid_o;
    logic              s_en_o;
    logic              last_o;
    logic              done_o;

    modport master (
        output data_i, valid_i, tick_i,
        input  ready_o, s_o, s_valid_o, s_en_o, last_o, done_o
    );

    modport slave (
        input  data_i, valid_i, tick_i,
        output ready_o, s_o, s_valid_o, s_en_o, last_o, done_o
    );

endinterface

// File: rtl/iob_piso_reg.sv
// Parallel-load, shift-left register; only the MSB is exposed as serial data.
module iob_piso_reg
    import iob_word_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              msb_o
);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = d_i;
        end else if (clr_i) begin
            sh_d = '0;
        end else if (shift_i) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else if (cke_i) begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_q[DATA_W-1];

endmodule

// File: rtl/iob_word_serializer.sv
// Word-to-bit serializer, MSB first, with a one-word holding buffer for gapless streaming.
module iob_word_serializer
    import iob_word_serializer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 rst_i,
    iob_word_serializer_if.slave io
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:0]        state_q, state_d;

    logic ready_c, s_valid_c, last_c, s_en_c, done_c;
    logic accept_c, load_c, shift_c, clr_c;
    logic msb_c;

    assign ready_c   = cke_i & ~buf_full_q;
    assign s_valid_c = (state_q == ST_SHIFT);
    assign last_c    = s_valid_c & (cnt_q == '0);
    assign s_en_c    = cke_i & io.tick_i & s_valid_c;
    assign done_c    = s_en_c & last_c;
    assign accept_c  = io.valid_i & ready_c;

    // A buffered word loads immediately from IDLE, or on the edge that consumes the last bit.
    assign load_c  = cke_i & buf_full_q & ((state_q == ST_IDLE) | done_c);
    assign shift_c = s_en_c & (cnt_q != '0);
    assign clr_c   = done_c & ~buf_full_q;

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        if (accept_c) begin
            buf_d      = io.data_i;
            buf_full_d = 1'b1;
        end
        if (load_c) begin
            cnt_d      = CNT_W'(DATA_W - 1);
            buf_full_d = 1'b0;
            state_d    = ST_SHIFT;
        end else if (shift_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (clr_c) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
        end else if (cke_i) begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    iob_piso_reg #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_i   (rst_i),
        .load_i  (load_c),
        .shift_i (shift_c),
        .clr_i   (clr_c),
        .d_i     (buf_q),
        .msb_o   (msb_c)
    );

    assign io.ready_o   = ready_c;
    assign io.s_o       = msb_c;
    assign io.s_valid_o = s_valid_c;
    assign io.s_en_o    = s_en_c;
    assign io.last_o    = last_c;
    assign io.done_o    = done_c;

endmodule

// File: tb/tb_iob_word_serializer.sv
// Directed bench for iob_word_serializer: words are scoreboarded on accept and checked against a model SIPO.
module tb_iob_word_serializer;

    localparam int unsigned W = 21;

    logic clk = 1'b0;
    logic cke;
    logic rst;

    iob_word_serializer_if #(.DATA_W(W)) io ();

    iob_word_serializer #(.DATA_W(W)) dut (
        .clk_i (clk),
        .cke_i (cke),
        .rst_i (rst),
        .io    (io)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] sipo;
    int           bitcnt;
    int           en_pulses;
    int           valid_cycles;
    int           words_done;
    int           n_cmp;
    int           n_err;
    int           cyc;
    bit           slow;
    bit           acc;
    logic         prev_s, prev_v, prev_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model SIPO fed by s_en_o/s_o, plus scoreboard push on every handshake.
    task automatic observe();
        logic [W-1:0] w;
        if (io.s_valid_o) valid_cycles++;
        if (io.s_valid_o && prev_v && !prev_en) chk("hold_between_ticks", 32'(io.s_o), 32'(prev_s));
        if (!io.s_valid_o) chk("no_en_when_idle", 32'(io.s_en_o), 32'd0);
        if (io.s_en_o) begin
            sipo = {sipo[W-2:0], io.s_o};
            bitcnt++;
            en_pulses++;
            chk("last_on_bit0", 32'(io.last_o), 32'(bitcnt == W));
            chk("done_on_bit0", 32'(io.done_o), 32'(bitcnt == W));
            if (bitcnt == W) begin
                chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("sipo_word", 32'(sipo), 32'(w));
                end
                bitcnt = 0;
                words_done++;
            end
        end else begin
            chk("done_without_en", 32'(io.done_o), 32'd0);
        end
        if (io.valid_i && io.ready_o) begin
            exp_q.push_back(io.data_i);
            acc = 1'b1;
        end
        prev_s  = io.s_o;
        prev_v  = io.s_valid_o;
        prev_en = io.s_en_o;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        io.tick_i = slow ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic send(input logic [W-1:0] w, output int waited);
        io.data_i  = w;
        io.valid_i = 1'b1;
        acc        = 1'b0;
        waited     = 0;
        while (!acc && waited < 200) begin
            step();
            waited++;
        end
        io.valid_i = 1'b0;
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || io.s_valid_o) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_time", 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_bits(input int b);
        int n = 0;
        while (bitcnt < b && n < 200) begin
            step();
            n++;
        end
        chk("wait_bits_in_time", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int   wt;
        int   b_en, b_v, b_w, c0, b_bits;
        logic saved;

        cke = 1'b1; rst = 1'b1;
        io.data_i = '0; io.valid_i = 1'b0; io.tick_i = 1'b1;
        slow = 1'b0; sipo = '0; prev_s = 1'b0; prev_v = 1'b0; prev_en = 1'b0;
        step();
        step();
        chk("rst_ready",   32'(io.ready_o),   32'd1);
        chk("rst_s_valid", 32'(io.s_valid_o), 32'd0);
        chk("rst_s",       32'(io.s_o),       32'd0);
        chk("rst_last",    32'(io.last_o),    32'd0);
        chk("rst_s_en",    32'(io.s_en_o),    32'd0);
        chk("rst_done",    32'(io.done_o),    32'd0);
        rst = 1'b0;

        // Single word, continuous ticks
        b_en = en_pulses; b_w = words_done;
        send(21'h15A5A5, wt);
        chk("lat_s_valid_low", 32'(io.s_valid_o), 32'd0);
        chk("lat_ready_low",   32'(io.ready_o),   32'd0);
        step();
        chk("lat_s_valid_high", 32'(io.s_valid_o), 32'd1);
        chk("first_bit_msb",    32'(io.s_o),       32'd1);
        drain(100);
        chk("single_pulses", 32'(en_pulses - b_en), 32'd21);
        chk("single_words",  32'(words_done - b_w), 32'd1);
        chk("single_idle",   32'(io.s_valid_o), 32'd0);

        // Back-to-back words must stream with no idle cycle
        b_en = en_pulses; b_v = valid_cycles; b_w = words_done;
        send(21'h000001, wt);
        send(21'h100000, wt);
        drain(200);
        chk("b2b_pulses",       32'(en_pulses - b_en),    32'd42);
        chk("b2b_valid_cycles", 32'(valid_cycles - b_v),  32'd42);
        chk("b2b_words",        32'(words_done - b_w),    32'd2);

        // Third word stalls until the second word loads
        b_w = words_done;
        send(21'h0F0F0F, wt);
        send(21'h1C3A5E, wt);
        send(21'h07E1F8, wt);
        chk("bp_wait_cycles", 32'(wt), 32'd21);
        drain(200);
        chk("bp_words", 32'(words_done - b_w), 32'd3);

        // Slow bit rate: one tick every third cycle
        slow = 1'b1; c0 = cyc; b_en = en_pulses; b_w = words_done;
        send(21'h0AAAAA, wt);
        drain(300);
        slow = 1'b0;
        chk("slow_pulses", 32'(en_pulses - b_en), 32'd21);
        chk("slow_words",  32'(words_done - b_w), 32'd1);
        chk("slow_min_cycles", 32'((cyc - c0) >= 61), 32'd1);

        // Reset mid-word with a second word buffered
        send(21'h133333, wt);
        send(21'h0CCCCC, wt);
        wait_bits(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        bitcnt = 0;
        sipo   = '0;
        chk("rstmid_s_valid", 32'(io.s_valid_o), 32'd0);
        chk("rstmid_ready",   32'(io.ready_o),   32'd1);
        repeat (3) begin
            step();
            chk("rstmid_buffer_dropped", 32'(io.s_valid_o), 32'd0);
        end
        b_w = words_done;
        send(21'h1ABCDE, wt);
        drain(100);
        chk("rstmid_fresh_word", 32'(words_done - b_w), 32'd1);

        // Clock enable low freezes everything mid-word
        b_w = words_done;
        send(21'h05D3C1, wt);
        wait_bits(8);
        cke = 1'b0;
        saved  = io.s_o;
        b_bits = bitcnt;
        repeat (5) begin
            step();
            chk("cke_s_en",  32'(io.s_en_o),  32'd0);
            chk("cke_ready", 32'(io.ready_o), 32'd0);
            chk("cke_s_o",   32'(io.s_o),     32'(saved));
        end
        chk("cke_no_bits", 32'(bitcnt), 32'(b_bits));
        cke = 1'b1;
        drain(100);
        chk("cke_words", 32'(words_done - b_w), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
